// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the scanned 4x4 keypad reader.
//   state_t   - scan FSM states
//   KEY_*     - matrix geometry
//   key_index - flat key number from (col,row), = col*4 + row
package key_pkg;

  typedef enum logic [1:0] {
    S_DRIVE  = 2'd0,
    S_SAMPLE = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;

  function automatic logic [3:0] key_index(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/key_prio16.sv
// key_prio16: combinational lowest-set-bit encoder.
//   req [15:0] in  - request vector
//   idx [3:0]  out - index of lowest set bit of req (0 when req == 0)
//   any        out - |req
module key_prio16
  import key_pkg::*;
(
  input  logic [KEY_NUM-1:0] req,
  output logic [3:0]         idx,
  output logic               any
);

  // Walk downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/key_scan.sv
// key_scan: scanned 4x4 matrix keypad reader with frame debounce.
//
// Ports:
//   clk        in   system clock
//   RST        in   synchronous active-high reset
//   KROW[3:0]  in   row lines, active-low, asynchronous
//   KCOL[3:0]  out  column drive, exactly one bit low
//   key_code   out  index of reported key (col*4 + row), held when idle
//   key_valid  out  one-cycle strobe per reported press
//   key_down   out  any debounced key held
//   key_map    out  debounced pressed map, 1 = pressed
//
// Build option: define KEY_REPEAT_EN to auto-repeat a lone held key every
// REPEAT_FRAMES frames. Without it REPEAT_FRAMES is unused.
//
// FSM states:
//   state    | meaning
//   S_DRIVE  | drive column col low, wait SCAN_DIV-1 cycles for rows to settle
//   S_SAMPLE | capture synchronized rows of column col into raw
//   S_COMMIT | whole frame sampled; run debounce and update key_map
module key_scan
  import key_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int DEB_CNT       = 4,
  parameter int REPEAT_FRAMES = 64
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [3:0]         KROW,
  output logic [3:0]         KCOL,
  output logic [3:0]         key_code,
  output logic               key_valid,
  output logic               key_down,
  output logic [KEY_NUM-1:0] key_map
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_CNT + 1);

  state_t              state, state_nxt;
  logic [SW-1:0]       slot_cnt;
  logic [1:0]          col;
  logic [3:0]          sync1, sync2, rows;
  logic [KEY_NUM-1:0]  raw, prev_raw, pending;
  logic [CW-1:0]       stable_cnt, stable_nxt;
  logic [3:0]          last_code, prio_idx;
  logic                prio_any;
  logic                drive_en, sample_en, commit_en, slot_last, map_upd;
  logic [KEY_NUM-1:0]  map_nxt, new_press, rep_bits, clr_mask;

  // Row synchronizer; idle (all released) after reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= KROW;
      sync2 <= sync1;
    end
  end

  assign rows      = ~sync2;
  assign slot_last = (slot_cnt == SW'(SCAN_DIV - 2));

  always_ff @(posedge clk) begin
    if (RST) state <= S_DRIVE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_DRIVE:  if (slot_last) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (col == 2'd3) ? S_COMMIT : S_DRIVE;
      S_COMMIT: state_nxt = S_DRIVE;
      default:  state_nxt = S_DRIVE;
    endcase
  end

  always_comb begin
    drive_en  = 1'b0;
    sample_en = 1'b0;
    commit_en = 1'b0;
    unique case (state)
      S_DRIVE:  drive_en  = 1'b1;
      S_SAMPLE: sample_en = 1'b1;
      S_COMMIT: commit_en = 1'b1;
      default:  drive_en  = 1'b0;
    endcase
  end

  // Column only advances on leaving S_SAMPLE/S_COMMIT, so KCOL (decoded
  // straight from col) never moves mid-slot.
  always_ff @(posedge clk) begin
    if (RST) begin
      slot_cnt <= '0;
      col      <= 2'd0;
      raw      <= '0;
    end else begin
      slot_cnt <= (drive_en && !slot_last) ? slot_cnt + SW'(1) : '0;
      if (sample_en) begin
        raw[key_index(col, 2'd0) +: KEY_ROWS] <= rows;
        if (col != 2'd3) col <= col + 2'd1;
      end
      if (commit_en) col <= 2'd0;
    end
  end

  assign KCOL = ~(4'b0001 << col);

  // Frame debounce: the map follows raw once DEB_CNT repeats of it are seen.
  always_comb begin
    if (raw != prev_raw)                 stable_nxt = '0;
    else if (stable_cnt == CW'(DEB_CNT)) stable_nxt = stable_cnt;
    else                                 stable_nxt = stable_cnt + CW'(1);
  end

  assign map_upd   = commit_en && (stable_nxt == CW'(DEB_CNT));
  assign map_nxt   = map_upd ? raw : key_map;
  assign new_press = map_upd ? (raw & ~key_map) : '0;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_cnt;
  logic          rep_hold, rep_fire;

  assign rep_hold = commit_en && (map_nxt == key_map) && $onehot(key_map);
  assign rep_fire = rep_hold && (rep_cnt == RW'(REPEAT_FRAMES - 1));
  assign rep_bits = rep_fire ? key_map : '0;

  always_ff @(posedge clk) begin
    if (RST) begin
      rep_cnt <= '0;
    end else if (commit_en) begin
      if (!rep_hold || rep_fire) rep_cnt <= '0;
      else                       rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_FRAMES;
  assign rep_bits      = '0;
`endif

  key_prio16 u_prio (
    .req (pending),
    .idx (prio_idx),
    .any (prio_any)
  );

  assign clr_mask = prio_any ? (KEY_NUM'(1) << prio_idx) : '0;

  always_ff @(posedge clk) begin
    if (RST) begin
      prev_raw   <= '0;
      stable_cnt <= '0;
      key_map    <= '0;
      pending    <= '0;
      last_code  <= 4'd0;
    end else begin
      if (commit_en) begin
        prev_raw   <= raw;
        stable_cnt <= stable_nxt;
      end
      key_map <= map_nxt;
      // Presses landing while the queue drains merge in; none are dropped.
      pending <= (pending & ~clr_mask) | new_press | rep_bits;
      if (prio_any) last_code <= prio_idx;
    end
  end

  // Gate with RST so a stale pending bit cannot strobe during reset.
  assign key_valid = prio_any && !RST;
  assign key_code  = prio_any ? prio_idx : last_code;
  assign key_down  = |key_map;

endmodule

// File: tb/tb_key_scan.sv
module tb_key_scan;

  localparam int SCAN_DIV      = 4;
  localparam int DEB_CNT       = 2;
  localparam int REPEAT_FRAMES = 8;
  localparam int FRAME         = 4 * SCAN_DIV + 1;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  KROW, KCOL, key_code;
  logic        key_valid, key_down;
  logic [15:0] key_map;

  logic [15:0] keys = '0;      // physically pressed keys
  logic [15:0] exp_map = '0;   // expected debounced map
  logic [3:0]  exp_q[$];       // expected reported key codes, in order
  bit          bounce_win = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  prev_kcol = 4'hE;
  logic        prev_rst = 1'b1;

  always #5 clk = ~clk;

  // Ideal keypad: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    KROW = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !KCOL[c]) KROW[r] = 1'b0;
  end

  key_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEB_CNT       (DEB_CNT),
    .REPEAT_FRAMES (REPEAT_FRAMES)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .KROW      (KROW),
    .KCOL      (KCOL),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .key_map   (key_map)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: column drive shape/order and every key_valid against the queue.
  always @(negedge clk) begin
    check("kcol_one_low", $countones(~KCOL), 1);
    if (!RST && !prev_rst && KCOL != prev_kcol)
      check("kcol_order", KCOL, {prev_kcol[2:0], prev_kcol[3]});
    if (key_valid === 1'b1) begin
      if (bounce_win || RST || exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got code %0d expected no strobe at %0t", key_code, $time);
      end else begin
        check("key_code", key_code, exp_q.pop_front());
      end
    end
    prev_kcol = KCOL;
    prev_rst  = RST;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    tick(n * FRAME);
  endtask

  // Change the pressed set at a frame start; the map must move exactly at
  // the third commit and every newly pressed key is reported in ascending order.
  task automatic press(input logic [15:0] nk, input string name);
    logic [15:0] newbits;
    newbits = nk & ~exp_map;
    keys = nk;
    tick(3 * FRAME - 1);
    check({name, "_map_before"}, key_map, exp_map);
    for (int i = 0; i < 16; i++) if (newbits[i]) exp_q.push_back(4'(i));
    tick(1);
    exp_map = nk;
    check({name, "_map_after"}, key_map, exp_map);
    check({name, "_key_down"}, key_down, (exp_map != 0));
    check({name, "_valid"}, key_valid, (newbits != 0));
  endtask

  initial begin
    logic [15:0] nk;
    int          n;

    // Power-up reset: three edges with RST high, release at a frame start.
    tick(3);
    RST = 1'b0;
    check("rst_kcol", KCOL, 4'hE);
    check("rst_map", key_map, 16'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_down", key_down, 1'b0);

    frames(10);
    check("idle_map", key_map, 16'h0);

    // Key 6, held six frames, then released.
    press(16'h0040, "k6");
    check("k6_code", key_code, 4'd6);
    frames(3);
    press(16'h0000, "k6_rel");

    // Key 0 bouncing every 5 cycles for three frames, then stable.
    bounce_win = 1'b1;
    for (int t = 0; t < 3 * FRAME; t++) begin
      keys = (((t / 5) % 2) == 0) ? 16'h0001 : 16'h0000;
      tick(1);
    end
    keys = 16'h0001;
    check("bounce_map_quiet", key_map, 16'h0);
    bounce_win = 1'b0;
    exp_q.push_back(4'd0);
    frames(4);
    exp_map = 16'h0001;
    check("bounce_map", key_map, exp_map);

    // Keys 3 and 12 in the same frame: two back-to-back strobes.
    press(16'h1009, "k3_k12");
    check("k3_code", key_code, 4'd3);
    tick(1);
    check("k12_valid", key_valid, 1'b1);
    check("k12_code", key_code, 4'd12);
    tick(1);
    check("drain_idle", key_valid, 1'b0);
    check("code_hold", key_code, 4'd12);
    tick(FRAME - 2);
    frames(1);
    press(16'h0000, "rel_all");

    // Reset in the middle of a slot while a new key is being scanned.
    keys = 16'h0200;
    tick(FRAME + 7);
    RST  = 1'b1;
    keys = 16'h0000;
    tick(1);
    RST = 1'b0;
    exp_map = 16'h0;
    check("mid_rst_kcol", KCOL, 4'hE);
    check("mid_rst_map", key_map, 16'h0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_down", key_down, 1'b0);
    frames(4);
    check("post_rst_map", key_map, 16'h0);

`ifdef KEY_REPEAT_EN
    // Lone key 5 repeats every REPEAT_FRAMES commits; a second key stops it.
    press(16'h0020, "k5");
    for (int k = 1; k <= 35; k++) begin
      frames(1);
      if (k % REPEAT_FRAMES == 0) exp_q.push_back(4'd5);
      check("repeat_valid", key_valid, (k % REPEAT_FRAMES == 0));
    end
    press(16'h0420, "k5_k10");
    frames(12);
    check("two_key_map", key_map, 16'h0420);
    press(16'h0000, "rep_rel");
`endif

    // Random key sets, each distinct from the last, held 3..6 frames.
    for (int it = 0; it < 12; it++) begin
      nk = '0;
      n  = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) nk[$urandom_range(0, 15)] = 1'b1;
      if (($urandom_range(0, 4)) == 0) nk = '0;
      if (nk == exp_map) nk = (exp_map == 16'h0) ? 16'h8000 : 16'h0000;
      press(nk, "rand");
      frames($urandom_range(0, 3));
    end
    press(16'h0000, "final_rel");

    frames(2);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
